// File: rtl/cmp_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cmp_arbiter_pkg
//   Shared definitions for the shared magnitude-comparator arbiter:
//   - FSM state encoding (IDLE / BUSY)
//   - comparator mode constants (unsigned / two's complement)
//   - result flag bundle
//   - id_bits(): width of a requester index, never narrower than one bit
// -----------------------------------------------------------------------------
package cmp_arbiter_pkg;

  typedef enum logic {
    CMP_ARB_IDLE = 1'b0,
    CMP_ARB_BUSY = 1'b1
  } cmp_arb_state_e;

  localparam logic CMP_MODE_UNSIGNED = 1'b0;
  localparam logic CMP_MODE_SIGNED   = 1'b1;

  localparam int unsigned STAT_W = 16;

  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } cmp_flags_t;

  // A single requester still needs a one-bit id port.
  function automatic int unsigned id_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : cmp_arbiter_pkg

// File: rtl/rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
//   Combinational round-robin winner selection, reusable by any arbiter that
//   shares one resource between NrOfReq users.
//
//   Ports:
//     req     in   NrOfReq  request vector
//     last    in   IdBits   index of the previous winner
//     onehot  out  NrOfReq  one-hot winner (all zero when req == 0)
//     idx     out  IdBits   winner index (0 when req == 0)
//     valid   out  1        at least one request present
//
//   The winner is the first set request strictly above 'last', wrapping to
//   index 0. The wrap is done as two linear passes so no modulo hardware is
//   needed for non-power-of-two requester counts.
// -----------------------------------------------------------------------------
module rr_picker
  import cmp_arbiter_pkg::*;
#(
  parameter  int NrOfReq = 2,
  localparam int IdBits  = id_bits(NrOfReq)
) (
  input  logic [NrOfReq-1:0] req,
  input  logic [IdBits-1:0]  last,
  output logic [NrOfReq-1:0] onehot,
  output logic [IdBits-1:0]  idx,
  output logic               valid
);

  always_comb begin
    // NOTE: every output gets a default before any conditional assignment,
    // otherwise the paths that find no request would infer latches.
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;

    // Pass 1: requesters after the previous winner.
    for (int i = 0; i < NrOfReq; i++) begin
      if (!valid && (i > int'(last)) && req[i]) begin
        valid     = 1'b1;
        idx       = IdBits'(i);
        onehot[i] = 1'b1;
      end
    end

    // Pass 2: wrap around to the requesters up to and including 'last'.
    for (int i = 0; i < NrOfReq; i++) begin
      if (!valid && (i <= int'(last)) && req[i]) begin
        valid     = 1'b1;
        idx       = IdBits'(i);
        onehot[i] = 1'b1;
      end
    end
  end

endmodule : rr_picker

// File: rtl/cmp_arbiter.sv
// -----------------------------------------------------------------------------
// cmp_arbiter
//   Shares one magnitude comparator between NrOfReq requesters (e.g. branch
//   condition logic and SLT/SLTU). Requesters are served round-robin; the
//   winner's operands and mode are captured at grant, compared in the
//   following cycle, and the flags come back as a one-cycle response tagged
//   with the requester id.
//
//   Timing: Req sampled at edge N -> Gnt high in cycle N+1 -> RespValid high
//   in cycle N+2. One compare per two cycles.
//
//   Ports:
//     Clock      in   1                  rising-edge clock
//     Reset      in   1                  asynchronous, active-high
//     Req        in   NrOfReq            request per requester, hold until Gnt
//     ReqSigned  in   NrOfReq            1 = two's complement, 0 = unsigned
//     ReqDataA   in   NrOfReq*NrOfBits   operand A, requester i at [i*NrOfBits +: NrOfBits]
//     ReqDataB   in   NrOfReq*NrOfBits   operand B, same layout
//     Gnt        out  NrOfReq            one-hot grant, one cycle
//     RespValid  out  1                  result-valid pulse
//     RespId     out  IdBits             requester owning the response
//     A_EQ_B     out  1                  A == B
//     A_GT_B     out  1                  A >  B (per mode)
//     A_LT_B     out  1                  A <  B (per mode)
//     StatCount  out  16                 completed-compare counter
//
//   Build option: define CMP_ARBITER_STATS_EN to get a saturating counter of
//   issued responses on StatCount; otherwise StatCount is tied to zero.
// -----------------------------------------------------------------------------
module cmp_arbiter
  import cmp_arbiter_pkg::*;
#(
  parameter  int NrOfBits = 32,
  parameter  int NrOfReq  = 2,
  localparam int IdBits   = id_bits(NrOfReq)
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic [NrOfReq-1:0]           Req,
  input  logic [NrOfReq-1:0]           ReqSigned,
  input  logic [NrOfReq*NrOfBits-1:0]  ReqDataA,
  input  logic [NrOfReq*NrOfBits-1:0]  ReqDataB,
  output logic [NrOfReq-1:0]           Gnt,
  output logic                         RespValid,
  output logic [IdBits-1:0]            RespId,
  output logic                         A_EQ_B,
  output logic                         A_GT_B,
  output logic                         A_LT_B,
  output logic [STAT_W-1:0]            StatCount
);

  cmp_arb_state_e      state_q, state_d;
  logic [IdBits-1:0]   last_q;
  logic [NrOfReq-1:0]  pick_onehot;
  logic [IdBits-1:0]   pick_idx;
  logic                pick_valid;
  logic                grant_en;
  logic                resp_en;
  logic [NrOfBits-1:0] op_a_q, op_b_q;
  logic                mode_q;
  cmp_flags_t          flags_d, flags_q;

  // ---------------------------------------------------------------------------
  // Round-robin selection
  // ---------------------------------------------------------------------------
  rr_picker #(
    .NrOfReq (NrOfReq)
  ) u_rr_picker (
    .req    (Req),
    .last   (last_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock or posedge Reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    if (Reset) state_q <= CMP_ARB_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    grant_en = 1'b0;
    resp_en  = 1'b0;
    case (state_q)
      CMP_ARB_IDLE: begin
        if (pick_valid) begin
          grant_en = 1'b1;
          state_d  = CMP_ARB_BUSY;
        end
      end
      CMP_ARB_BUSY: begin
        // Requests arriving now simply wait; they are re-sampled in IDLE.
        resp_en = 1'b1;
        state_d = CMP_ARB_IDLE;
      end
      default: state_d = CMP_ARB_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control and response registers
  // ---------------------------------------------------------------------------
  // last_q doubles as the in-flight id: it is written with the winner at
  // grant and is not touched again until the response has been issued.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      last_q    <= IdBits'(NrOfReq - 1);
      Gnt       <= '0;
      RespValid <= 1'b0;
      RespId    <= '0;
      flags_q   <= '0;
    end else begin
      Gnt       <= grant_en ? pick_onehot : '0;
      RespValid <= resp_en;
      if (grant_en) last_q <= pick_idx;
      if (resp_en) begin
        RespId  <= last_q;
        flags_q <= flags_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Operand capture
  // ---------------------------------------------------------------------------
  // NOTE: the operand/mode registers are deliberately left without reset:
  // they are only read in BUSY, which is always entered through a capture,
  // so their power-up contents can never reach an output.
  always_ff @(posedge Clock) begin
    if (grant_en) begin
      op_a_q <= ReqDataA[int'(pick_idx) * NrOfBits +: NrOfBits];
      op_b_q <= ReqDataB[int'(pick_idx) * NrOfBits +: NrOfBits];
      mode_q <= ReqSigned[pick_idx] ? CMP_MODE_SIGNED : CMP_MODE_UNSIGNED;
    end
  end

  // ---------------------------------------------------------------------------
  // Shared comparator on the captured operands
  // ---------------------------------------------------------------------------
  always_comb begin
    flags_d    = '0;
    flags_d.eq = (op_a_q == op_b_q);
    if (mode_q == CMP_MODE_SIGNED) begin
      flags_d.gt = ($signed(op_a_q) > $signed(op_b_q));
      flags_d.lt = ($signed(op_a_q) < $signed(op_b_q));
    end else begin
      flags_d.gt = (op_a_q > op_b_q);
      flags_d.lt = (op_a_q < op_b_q);
    end
  end

  assign A_EQ_B = flags_q.eq;
  assign A_GT_B = flags_q.gt;
  assign A_LT_B = flags_q.lt;

  // ---------------------------------------------------------------------------
  // Optional response counter
  // ---------------------------------------------------------------------------
`ifdef CMP_ARBITER_STATS_EN
  logic [STAT_W-1:0] stat_q;

  // Counts on the same edge that raises RespValid, so StatCount already
  // includes the response being presented.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)                        stat_q <= '0;
    else if (resp_en && !(&stat_q))   stat_q <= stat_q + 1'b1;
  end

  assign StatCount = stat_q;
`else
  assign StatCount = '0;
`endif

endmodule : cmp_arbiter
